// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet host-bus blocks: bus cycle FSM states,
// sequencer mode codes and bus geometry.
package eth_pkg;

    localparam int unsigned BUS_W = 16;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StRecover
    } bus_state_e;

    typedef enum logic [1:0] {
        ModeInit     = 2'b00,
        ModeTransmit = 2'b01,
        ModeReceive  = 2'b10,
        ModeIdle     = 2'b11
    } mode_e;

    // Down-counter preload for a phase lasting 'cycles' clock cycles (1..16).
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/eth_bus_cycle_if.sv
// Request/response bundle between the mode multiplexer and the bus cycle engine.
interface eth_bus_cycle_if;
    import eth_pkg::*;

    logic             req;
    logic             req_wr;
    logic             req_cmd;
    logic [BUS_W-1:0] req_data;
    logic             busy;
    logic             done;
    logic [BUS_W-1:0] rdata;

    modport master (
        output req,
        output req_wr,
        output req_cmd,
        output req_data,
        input  busy,
        input  done,
        input  rdata
    );

    modport slave (
        input  req,
        input  req_wr,
        input  req_cmd,
        input  req_data,
        output busy,
        output done,
        output rdata
    );

endinterface

// File: rtl/eth_bus_cycle.sv
// Single-transaction engine for the MAC/PHY 16-bit async host bus: strobe timing,
// SD drive/tristate control and read data capture. All bus pins are registered.
module eth_bus_cycle
    import eth_pkg::*;
#(
    parameter int unsigned STROBE_CYC  = 4,
    parameter int unsigned RECOVER_CYC = 2
) (
    input  logic             sysclk,
    input  logic             reset,
    eth_bus_cycle_if.slave   host,
    output logic             ETH_CSn,
    output logic             ETH_RDn,
    output logic             ETH_WRn,
    output logic             ETH_CMD,
    output logic [BUS_W-1:0] SD_out,
    output logic             SD_oe,
    input  logic [BUS_W-1:0] SD_in
);

    localparam logic [CNT_W-1:0] STROBE_LOAD  = cnt_load(STROBE_CYC);
    localparam logic [CNT_W-1:0] RECOVER_LOAD = cnt_load(RECOVER_CYC);

    bus_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic             csn_q, csn_d;
    logic             rdn_q, rdn_d;
    logic             wrn_q, wrn_d;
    logic             cmd_q, cmd_d;
    logic             oe_q, oe_d;
    logic [BUS_W-1:0] sdout_q, sdout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [BUS_W-1:0] rdata_q, rdata_d;

    // Next-state logic computes the pin values for the *next* cycle, so every
    // output comes straight from a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        csn_d   = csn_q;
        rdn_d   = rdn_q;
        wrn_d   = wrn_q;
        cmd_d   = cmd_q;
        oe_d    = oe_q;
        sdout_d = sdout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (host.req) begin
                    state_d = StSetup;
                    wr_d    = host.req_wr;
                    busy_d  = 1'b1;
                    csn_d   = 1'b0;
                    cmd_d   = host.req_cmd;
                    oe_d    = host.req_wr;
                    sdout_d = host.req_wr ? host.req_data : '0;
                end
            end
            StSetup: begin
                state_d = StStrobe;
                cnt_d   = STROBE_LOAD;
                if (wr_q) begin
                    wrn_d = 1'b0;
                end else begin
                    rdn_d = 1'b0;
                end
            end
            StStrobe: begin
                if (cnt_q == '0) begin
                    state_d = StHold;
                    rdn_d   = 1'b1;
                    wrn_d   = 1'b1;
                    // Sample while RDn is still low at this edge.
                    if (!wr_q) begin
                        rdata_d = SD_in;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHold: begin
                state_d = StRecover;
                cnt_d   = RECOVER_LOAD;
                csn_d   = 1'b1;
                oe_d    = 1'b0;
                cmd_d   = 1'b0;
            end
            StRecover: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            csn_q   <= 1'b1;
            rdn_q   <= 1'b1;
            wrn_q   <= 1'b1;
            cmd_q   <= 1'b0;
            oe_q    <= 1'b0;
            sdout_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            csn_q   <= csn_d;
            rdn_q   <= rdn_d;
            wrn_q   <= wrn_d;
            cmd_q   <= cmd_d;
            oe_q    <= oe_d;
            sdout_q <= sdout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    assign ETH_CSn    = csn_q;
    assign ETH_RDn    = rdn_q;
    assign ETH_WRn    = wrn_q;
    assign ETH_CMD    = cmd_q;
    assign SD_out     = sdout_q;
    assign SD_oe      = oe_q;
    assign host.busy  = busy_q;
    assign host.done  = done_q;
    assign host.rdata = rdata_q;

`ifndef SYNTHESIS
    // Bus-contention and strobe-qualification invariants.
    always @(posedge sysclk) begin
        if (!reset) begin
            assert (rdn_q || wrn_q);
            assert (!csn_q || (rdn_q && wrn_q));
            assert (!(oe_q && !wr_q));
            assert (!(oe_q && (state_q == StRecover || state_q == StIdle)));
        end
    end
`endif

endmodule

// File: tb/tb_eth_bus_cycle.sv
// Directed bench for eth_bus_cycle: default, minimum and maximum timing builds
// share one stimulus sequence, selected through 'sel'.
module tb_eth_bus_cycle;
    import eth_pkg::*;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        req, req_wr, req_cmd;
    logic [15:0] req_data, sd_in;
    int          sel;

    always #5 sysclk = ~sysclk;

    eth_bus_cycle_if bus0 ();
    eth_bus_cycle_if bus1 ();
    eth_bus_cycle_if bus2 ();

    logic        csn [3];
    logic        rdn [3];
    logic        wrn [3];
    logic        cmd [3];
    logic        oe  [3];
    logic [15:0] sdo [3];

    assign bus0.req = req && (sel == 0);
    assign bus1.req = req && (sel == 1);
    assign bus2.req = req && (sel == 2);
    assign bus0.req_wr = req_wr;
    assign bus1.req_wr = req_wr;
    assign bus2.req_wr = req_wr;
    assign bus0.req_cmd = req_cmd;
    assign bus1.req_cmd = req_cmd;
    assign bus2.req_cmd = req_cmd;
    assign bus0.req_data = req_data;
    assign bus1.req_data = req_data;
    assign bus2.req_data = req_data;

    eth_bus_cycle #(.STROBE_CYC(4), .RECOVER_CYC(2)) dut0 (
        .sysclk(sysclk), .reset(reset), .host(bus0),
        .ETH_CSn(csn[0]), .ETH_RDn(rdn[0]), .ETH_WRn(wrn[0]), .ETH_CMD(cmd[0]),
        .SD_out(sdo[0]), .SD_oe(oe[0]), .SD_in(sd_in)
    );
    eth_bus_cycle #(.STROBE_CYC(1), .RECOVER_CYC(1)) dut1 (
        .sysclk(sysclk), .reset(reset), .host(bus1),
        .ETH_CSn(csn[1]), .ETH_RDn(rdn[1]), .ETH_WRn(wrn[1]), .ETH_CMD(cmd[1]),
        .SD_out(sdo[1]), .SD_oe(oe[1]), .SD_in(sd_in)
    );
    eth_bus_cycle #(.STROBE_CYC(16), .RECOVER_CYC(16)) dut2 (
        .sysclk(sysclk), .reset(reset), .host(bus2),
        .ETH_CSn(csn[2]), .ETH_RDn(rdn[2]), .ETH_WRn(wrn[2]), .ETH_CMD(cmd[2]),
        .SD_out(sdo[2]), .SD_oe(oe[2]), .SD_in(sd_in)
    );

    logic        o_csn, o_rdn, o_wrn, o_cmd, o_oe, o_busy, o_done;
    logic [15:0] o_sdo, o_rdata;

    always_comb begin
        o_csn   = csn[sel];
        o_rdn   = rdn[sel];
        o_wrn   = wrn[sel];
        o_cmd   = cmd[sel];
        o_oe    = oe[sel];
        o_sdo   = sdo[sel];
        o_busy  = bus0.busy;
        o_done  = bus0.done;
        o_rdata = bus0.rdata;
        case (sel)
            1: begin o_busy = bus1.busy; o_done = bus1.done; o_rdata = bus1.rdata; end
            2: begin o_busy = bus2.busy; o_done = bus2.done; o_rdata = bus2.rdata; end
            default: ;
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Per-transaction observations, gathered once per cycle #1 after the edge.
    int          csn_low, rdn_low, wrn_low, oe_cyc, fall_cnt, gap_run, last_gap, refall_k;
    int          done_cnt, done_k, done_k2, bad_sd, bad_cmd, bad_bus;
    logic        prev_low;
    logic [15:0] exp_sd, rdata_at_done;
    logic        exp_cmd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        csn_low = 0; rdn_low = 0; wrn_low = 0; oe_cyc = 0; fall_cnt = 0;
        gap_run = 0; last_gap = -1; refall_k = -1; done_cnt = 0; done_k = -1;
        done_k2 = -1; bad_sd = 0; bad_cmd = 0; bad_bus = 0; prev_low = 1'b0;
        rdata_at_done = 16'hxxxx;
    endtask

    task automatic sample(input int k);
        if (!o_csn) begin
            csn_low++;
            if (!prev_low) begin
                fall_cnt++;
                if (fall_cnt > 1) begin
                    last_gap = gap_run;
                    refall_k = k;
                end
            end
            gap_run = 0;
            if (o_cmd !== exp_cmd) bad_cmd++;
        end else begin
            gap_run++;
        end
        prev_low = !o_csn;
        if (!o_rdn) rdn_low++;
        if (!o_wrn) wrn_low++;
        if (o_oe) begin
            oe_cyc++;
            if (o_sdo !== exp_sd) bad_sd++;
        end
        if (!o_rdn && !o_wrn) bad_bus++;
        if (o_csn && (!o_rdn || !o_wrn)) bad_bus++;
        if (o_done) begin
            done_cnt++;
            if (done_cnt == 1) done_k = k;
            else done_k2 = k;
            rdata_at_done = o_rdata;
            if (o_busy) bad_bus++;
        end
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; req_wr = 1'b0; req_cmd = 1'b0;
        req_data = '0; sd_in = '0; sel = 0;
        exp_sd = '0; exp_cmd = 1'b0;
        clear_stats();
        repeat (3) @(posedge sysclk);
        #1;
        check("rst_csn", {31'd0, o_csn}, 1);
        check("rst_rdn", {31'd0, o_rdn}, 1);
        check("rst_wrn", {31'd0, o_wrn}, 1);
        check("rst_cmd", {31'd0, o_cmd}, 0);
        check("rst_oe", {31'd0, o_oe}, 0);
        check("rst_sdo", {16'd0, o_sdo}, 0);
        check("rst_busy", {31'd0, o_busy}, 0);
        check("rst_done", {31'd0, o_done}, 0);
        check("rst_rdata", {16'd0, o_rdata}, 0);
        reset = 1'b0;

        // Write, default timing: accept on edge k=1, done visible after edge 9.
        clear_stats();
        exp_sd = 16'h0310; exp_cmd = 1'b1;
        req = 1'b1; req_wr = 1'b1; req_cmd = 1'b1; req_data = 16'h0310;
        for (int k = 1; k <= 14; k++) begin
            @(posedge sysclk); #1;
            sample(k);
            if (k == 1) check("wr_busy", {31'd0, o_busy}, 1);
            if (o_done) req = 1'b0;
        end
        check("wr_csn_low", csn_low, 6);
        check("wr_wrn_low", wrn_low, 4);
        check("wr_rdn_low", rdn_low, 0);
        check("wr_oe_cyc", oe_cyc, 6);
        check("wr_sd_val", bad_sd, 0);
        check("wr_cmd", bad_cmd, 0);
        check("wr_done_cnt", done_cnt, 1);
        check("wr_latency", done_k, 9);
        check("wr_bus_rules", bad_bus, 0);
        check("wr_busy_end", {31'd0, o_busy}, 0);

        // Read, default timing; rdata must survive a later SD_in change.
        clear_stats();
        exp_cmd = 1'b0; sd_in = 16'hA5C3;
        req = 1'b1; req_wr = 1'b0; req_cmd = 1'b0; req_data = 16'hFFFF;
        for (int k = 1; k <= 12; k++) begin
            @(posedge sysclk); #1;
            sample(k);
            if (o_done) begin
                req = 1'b0;
                sd_in = 16'h1234;
            end
        end
        check("rd_rdn_low", rdn_low, 4);
        check("rd_wrn_low", wrn_low, 0);
        check("rd_oe_cyc", oe_cyc, 0);
        check("rd_latency", done_k, 9);
        check("rd_done_cnt", done_cnt, 1);
        check("rd_rdata", {16'd0, rdata_at_done}, 32'hA5C3);
        check("rd_rdata_hold", {16'd0, o_rdata}, 32'hA5C3);
        check("rd_bus_rules", bad_bus, 0);

        // Back-to-back write then read with req held. CSn stays high through
        // RECOVER plus the IDLE cycle in which done is shown.
        clear_stats();
        exp_sd = 16'h0310; exp_cmd = 1'b1; sd_in = 16'h5A3C;
        req = 1'b1; req_wr = 1'b1; req_cmd = 1'b1; req_data = 16'h0310;
        for (int k = 1; k <= 22; k++) begin
            @(posedge sysclk); #1;
            sample(k);
            if (o_done) begin
                if (done_cnt == 1) req_wr = 1'b0;
                else req = 1'b0;
            end
        end
        check("b2b_done_cnt", done_cnt, 2);
        check("b2b_done1", done_k, 9);
        check("b2b_done2", done_k2, 18);
        check("b2b_refall", refall_k, 10);
        check("b2b_gap", last_gap, 3);
        check("b2b_wrn_low", wrn_low, 4);
        check("b2b_rdn_low", rdn_low, 4);
        check("b2b_oe_cyc", oe_cyc, 6);
        check("b2b_rdata", {16'd0, rdata_at_done}, 32'h5A3C);
        check("b2b_bus_rules", bad_bus, 0);

        // Request pulsed while busy must be ignored.
        clear_stats();
        exp_sd = 16'hBEEF; exp_cmd = 1'b1;
        req = 1'b1; req_wr = 1'b1; req_cmd = 1'b1; req_data = 16'hBEEF;
        for (int k = 1; k <= 14; k++) begin
            @(posedge sysclk); #1;
            sample(k);
            if (k == 1) req = 1'b0;
            if (k == 3) begin
                check("bsy_busy", {31'd0, o_busy}, 1);
                req = 1'b1;
            end
            if (k == 4) req = 1'b0;
        end
        check("bsy_done_cnt", done_cnt, 1);
        check("bsy_latency", done_k, 9);
        check("bsy_txn_cnt", fall_cnt, 1);
        check("bsy_wrn_low", wrn_low, 4);
        check("bsy_csn_low", csn_low, 6);

        // Reset during the write strobe aborts without done.
        clear_stats();
        exp_sd = 16'h0F0F;
        req = 1'b1; req_wr = 1'b1; req_cmd = 1'b1; req_data = 16'h0F0F;
        for (int k = 1; k <= 14; k++) begin
            @(posedge sysclk); #1;
            sample(k);
            if (k == 2) begin
                check("rstm_in_strobe", {31'd0, o_wrn}, 0);
                reset = 1'b1;
                req = 1'b0;
            end
            if (k == 3) begin
                check("rstm_wrn", {31'd0, o_wrn}, 1);
                check("rstm_csn", {31'd0, o_csn}, 1);
                check("rstm_oe", {31'd0, o_oe}, 0);
                check("rstm_busy", {31'd0, o_busy}, 0);
                check("rstm_done", {31'd0, o_done}, 0);
                reset = 1'b0;
            end
        end
        check("rstm_no_done", done_cnt, 0);

        clear_stats();
        exp_cmd = 1'b0; sd_in = 16'h3C96;
        req = 1'b1; req_wr = 1'b0; req_cmd = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge sysclk); #1;
            sample(k);
            if (o_done) req = 1'b0;
        end
        check("rstm_rd_latency", done_k, 9);
        check("rstm_rd_rdata", {16'd0, rdata_at_done}, 32'h3C96);
        check("rstm_rd_rdn_low", rdn_low, 4);

        // Minimum timing build: 1-cycle strobe, done 4 edges after accept.
        sel = 1;
        clear_stats();
        exp_sd = 16'h1111; exp_cmd = 1'b1;
        req = 1'b1; req_wr = 1'b1; req_cmd = 1'b1; req_data = 16'h1111;
        for (int k = 1; k <= 8; k++) begin
            @(posedge sysclk); #1;
            sample(k);
            if (o_done) req = 1'b0;
        end
        check("min_wrn_low", wrn_low, 1);
        check("min_csn_low", csn_low, 3);
        check("min_oe_cyc", oe_cyc, 3);
        check("min_latency", done_k, 5);
        check("min_sd_val", bad_sd, 0);

        // Maximum timing build: 16-cycle strobe, done 34 edges after accept.
        sel = 2;
        clear_stats();
        exp_cmd = 1'b0; sd_in = 16'hC0DE;
        req = 1'b1; req_wr = 1'b0; req_cmd = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge sysclk); #1;
            sample(k);
            if (o_done) req = 1'b0;
        end
        check("max_rdn_low", rdn_low, 16);
        check("max_csn_low", csn_low, 18);
        check("max_latency", done_k, 35);
        check("max_rdata", {16'd0, rdata_at_done}, 32'hC0DE);
        check("max_done_cnt", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
